// File: rtl/rtc_pb_conditioner.sv
// rtc_pb_conditioner: synchronises, debounces and edge-detects active-low push buttons
// into one-cycle press pulses. Define RTC_PB_AUTOREPEAT_EN to add hold-to-repeat pulses.
module rtc_pb_conditioner #(
    parameter int N_BUT      = 3,
    parameter int DB_CYCLES  = 1_000_000,
    parameter int REP_DELAY  = 25_000_000,
    parameter int REP_PERIOD = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BUT-1:0] but_raw,
    output logic [N_BUT-1:0] push_but,
    output logic [N_BUT-1:0] but_level
);

    localparam int DBC_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DB_CYCLES - 1);

    // An illegal parameter set trips this assertion on every clock in simulation.
    localparam bit CFG_OK = (DB_CYCLES >= 2) && (REP_DELAY >= 1) && (REP_PERIOD >= 1);
    if (!CFG_OK) begin : g_cfg_check
        cfg_invalid_a: assert property (@(posedge clk) 1'b0);
    end

`ifdef RTC_PB_AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RPC_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [RPC_W-1:0] DELAY_LAST  = RPC_W'(REP_DELAY - 1);
    localparam logic [RPC_W-1:0] PERIOD_LAST = RPC_W'(REP_PERIOD - 1);
`endif

    genvar gi;
    for (gi = 0; gi < N_BUT; gi++) begin : g_but
        logic             s1_q;
        logic             s2_q;
        logic             stable_q;
        logic             stable_d;
        logic [DBC_W-1:0] dbc_q;
        logic [DBC_W-1:0] dbc_d;
        logic             level_q;
        logic             level_d;
        logic             push_q;
        logic             push_d;
        logic             press_ev;

        // Any mismatch run shorter than the window is discarded by the level-match clear.
        always_comb begin
            dbc_d    = dbc_q;
            stable_d = stable_q;
            if (s2_q == stable_q) begin
                dbc_d = '0;
            end else if (dbc_q == DBC_LAST) begin
                stable_d = s2_q;
                dbc_d    = '0;
            end else begin
                dbc_d = dbc_q + 1'b1;
            end
        end

        assign press_ev = stable_q & ~stable_d;
        assign level_d  = ~stable_d;

`ifdef RTC_PB_AUTOREPEAT_EN
        logic             release_ev;
        logic [RPC_W-1:0] rpc_q;
        logic [RPC_W-1:0] rpc_d;
        logic             rep_phase_q;
        logic             rep_phase_d;
        logic             rep_hit;

        assign release_ev = ~stable_q & stable_d;

        // Release wins over a coinciding repeat threshold so no pulse accompanies it.
        always_comb begin
            rpc_d       = rpc_q;
            rep_phase_d = rep_phase_q;
            rep_hit     = 1'b0;
            if (press_ev || release_ev) begin
                rpc_d       = '0;
                rep_phase_d = 1'b0;
            end else if (level_q) begin
                if (rpc_q == (rep_phase_q ? PERIOD_LAST : DELAY_LAST)) begin
                    rep_hit     = 1'b1;
                    rpc_d       = '0;
                    rep_phase_d = 1'b1;
                end else begin
                    rpc_d = rpc_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rpc_q       <= '0;
                rep_phase_q <= 1'b0;
            end else begin
                rpc_q       <= rpc_d;
                rep_phase_q <= rep_phase_d;
            end
        end

        assign push_d = press_ev | rep_hit;
`else
        assign push_d = press_ev;
`endif

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1_q     <= 1'b1;
                s2_q     <= 1'b1;
                stable_q <= 1'b1;
                dbc_q    <= '0;
                level_q  <= 1'b0;
                push_q   <= 1'b0;
            end else begin
                s1_q     <= but_raw[gi];
                s2_q     <= s1_q;
                stable_q <= stable_d;
                dbc_q    <= dbc_d;
                level_q  <= level_d;
                push_q   <= push_d;
            end
        end

        assign push_but[gi]  = push_q;
        assign but_level[gi] = level_q;
    end

endmodule
